instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_WIDTH, default 8, instruction address width in bits.
REQ-002 Parameter INSTR_WIDTH, default 16, instruction word width in bits.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-low.
REQ-005 Port o_rom_addr  output  PC_WIDTH  fetch address to instruction ROM; equals internal PC register.
REQ-006 Port i_rom_data  input  INSTR_WIDTH  ROM word at o_rom_addr, combinational same-cycle return.
REQ-007 Port o_valid  output  1  queue head holds a valid instruction.
REQ-008 Port i_ready  input  1  decode stage accepts head this cycle.
REQ-009 Port o_instr  output  INSTR_WIDTH  instruction at queue head.
REQ-010 Port o_pc  output  PC_WIDTH  address of instruction at queue head.
REQ-011 Port i_redirect  input  1  branch/jump taken; flush and refetch.
REQ-012 Port i_redirect_pc  input  PC_WIDTH  new fetch address, sampled when i_redirect=1.
REQ-013 Port o_halted  output  1  fetch stopped on HALT instruction.

Function
REQ-014 Queue SHALL be 2 entries, each {pc, instr}; FIFO order; count range 0..2.
REQ-015 o_valid SHALL equal (count != 0); o_instr/o_pc SHALL be head entry, registered (no combinational path from i_rom_data).
REQ-016 Pop SHALL occur when o_valid=1 and i_ready=1.
REQ-017 States: FETCH, HALTED; o_halted=1 iff state==HALTED.
REQ-018 In FETCH, push SHALL occur when count<2, or count==2 with pop same cycle; push writes {PC, i_rom_data}, PC <= PC+1.
REQ-019 In FETCH with no push possible (count==2, no pop), PC and queue contents SHALL hold.
REQ-020 PC increment SHALL wrap modulo 2^PC_WIDTH (all-ones -> 0).
REQ-021 HALT encoding: i_rom_data[15:13]=3'b111 and [2:0]=3'b111; when pushed, PC SHALL not increment and state -> HALTED same edge.
REQ-022 In HALTED, no pushes; pops continue until queue drains; PC holds.
REQ-023 i_redirect=1 SHALL take priority over push/pop: count <= 0, PC <= i_redirect_pc, state <= FETCH (also from HALTED), no push that cycle; any simultaneous pop is discarded.
REQ-024 Latency: word at address A is visible on o_instr the cycle after PC==A with push, i.e. 1 cycle; sustained throughput 1 instr/cycle when i_ready held high.
REQ-025 Simultaneous push and pop at count 1 or 2 SHALL leave count unchanged; at count 0 only push applies.
REQ-026 Queue storage for non-valid entries is don't-care; o_instr/o_pc undefined-but-stable when o_valid=0.

Reset
REQ-027 On rising clk with rst=0: PC=0, count=0, state=FETCH, o_valid=0, o_halted=0, o_rom_addr=0.
REQ-028 Reset SHALL override redirect, push and pop in the same cycle; mid-operation reset discards queue contents.
REQ-029 First fetch (address 0) SHALL be pushed on the first edge with rst=1.

Verification
REQ-030 Reset release, i_ready=1, ROM[n]=16'h0100+n -> o_instr 0100,0101,0102 on consecutive cycles, o_pc 0,1,2, first o_valid one cycle after release.
REQ-031 i_ready=0 for 5 cycles from reset -> count saturates at 2, o_rom_addr stalls at 2, o_instr stays ROM[0]; i_ready=1 -> ROM[0],ROM[1],ROM[2] in order, no loss or duplicate.
REQ-032 PC_WIDTH=8, redirect to 8'hFE, i_ready=1 -> o_pc sequence FE, FF, 00, 01.
REQ-033 ROM[3]=16'hE007 (HALT), i_ready=1 -> o_pc 0..3 delivered, o_halted=1 after push of 3, o_rom_addr holds 3, o_valid=0 after drain; then redirect to 8'h10 -> o_halted=0, o_pc=10 next valid.
REQ-034 Queue full (count 2), i_redirect=1 with i_ready=1 to 8'h40 -> next cycle o_valid=0, o_rom_addr=40; following cycle o_pc=40.
REQ-035 rst=0 asserted for one cycle while count=2 and i_redirect=1 -> o_valid=0, o_rom_addr=0, redirect ignored.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction ROM port, decode-side queue head, and redirect request.
interface instr_fetch_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic [PC_WIDTH-1:0]    o_rom_addr;
  logic [INSTR_WIDTH-1:0] i_rom_data;
  logic                   o_valid;
  logic                   i_ready;
  logic [INSTR_WIDTH-1:0] o_instr;
  logic [PC_WIDTH-1:0]    o_pc;
  logic                   i_redirect;
  logic [PC_WIDTH-1:0]    i_redirect_pc;
  logic                   o_halted;

  modport master (
    output o_rom_addr, o_valid, o_instr, o_pc, o_halted,
    input  i_rom_data, i_ready, i_redirect, i_redirect_pc
  );

  modport slave (
    input  o_rom_addr, o_valid, o_instr, o_pc, o_halted,
    output i_rom_data, i_ready, i_redirect, i_redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, combinational-ROM fetch, 2-entry {pc,instr} queue,
// HALT detection and redirect flush.
module instr_fetch #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);
  typedef enum logic {FETCH, HALTED} state_t;

  state_t                 state;
  logic                   halted;
  logic [PC_WIDTH-1:0]    pc;
  logic [1:0]             count;
  logic [PC_WIDTH-1:0]    q_pc    [2];
  logic [INSTR_WIDTH-1:0] q_instr [2];

  logic pop;
  logic push;
  logic wr_hi;
  logic is_halt;

  always_comb begin
    pop     = (count != 2'd0) && bus.i_ready;
    push    = (state == FETCH) && ((count != 2'd2) || pop);
    // New entry lands behind whatever survives this cycle's pop.
    wr_hi   = (count == 2'd2) || ((count == 2'd1) && !pop);
    is_halt = (bus.i_rom_data[15:13] == 3'b111) && (bus.i_rom_data[2:0] == 3'b111);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc     <= '0;
      count  <= '0;
      state  <= FETCH;
      halted <= 1'b0;
    end else if (bus.i_redirect) begin
      pc     <= bus.i_redirect_pc;
      count  <= '0;
      state  <= FETCH;
      halted <= 1'b0;
    end else begin
      if (pop) begin
        q_pc[0]    <= q_pc[1];
        q_instr[0] <= q_instr[1];
      end
      if (push) begin
        // A slot-0 write overrides the shift above (pop+push at count 1).
        if (wr_hi) begin
          q_pc[1]    <= pc;
          q_instr[1] <= bus.i_rom_data;
        end else begin
          q_pc[0]    <= pc;
          q_instr[0] <= bus.i_rom_data;
        end
        if (is_halt) begin
          state  <= HALTED;
          halted <= 1'b1;
        end else begin
          pc <= pc + PC_WIDTH'(1);
        end
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.o_rom_addr = pc;
  assign bus.o_valid    = (count != 2'd0);
  assign bus.o_instr    = q_instr[0];
  assign bus.o_pc       = q_pc[0];
  assign bus.o_halted   = halted;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run against a queue-based model.
module tb_instr_fetch;
  localparam int PW = 8;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();
  instr_fetch #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [IW-1:0] rom [256];
  assign bus.i_rom_data = rom[bus.o_rom_addr];

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] mq_pc [$];
  logic [IW-1:0] mq_in [$];
  logic [PW-1:0] mpc;
  logic          mhalt;

  function automatic logic halt_word(logic [IW-1:0] w);
    return (w[15:13] == 3'b111) && (w[2:0] == 3'b111);
  endfunction

  task automatic tick();
    logic [IW-1:0] w;
    @(posedge clk);
    if (!rst) begin
      mq_pc.delete(); mq_in.delete(); mpc = '0; mhalt = 1'b0;
    end else if (bus.i_redirect) begin
      mq_pc.delete(); mq_in.delete(); mpc = bus.i_redirect_pc; mhalt = 1'b0;
    end else begin
      if (mq_pc.size() > 0 && bus.i_ready) begin
        void'(mq_pc.pop_front()); void'(mq_in.pop_front());
      end
      if (!mhalt && mq_pc.size() < 2) begin
        w = rom[mpc];
        mq_pc.push_back(mpc); mq_in.push_back(w);
        if (halt_word(w)) mhalt = 1'b1;
        else mpc = mpc + 8'd1;
      end
    end
    #1;
  endtask

  task automatic fill_rom_linear();
    for (int n = 0; n < 256; n++) rom[n] = 16'h0100 + 16'(n);
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.i_ready = 1'b0; bus.i_redirect = 1'b0; bus.i_redirect_pc = '0;
    fill_rom_linear();
    tick(); tick();
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_rom_addr !== 8'h00) begin failures++; $display("FAIL reset_addr: got %h want 00", bus.o_rom_addr); end
    checks++; if (bus.o_halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b want 0", bus.o_halted); end
  endtask

  task automatic test_stream();
    rst = 1'b0; bus.i_ready = 1'b1; tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.o_valid); end
      checks++; if (bus.o_pc !== 8'(i)) begin failures++; $display("FAIL stream_pc[%0d]: got %h want %h", i, bus.o_pc, 8'(i)); end
      checks++; if (bus.o_instr !== 16'h0100 + 16'(i)) begin failures++; $display("FAIL stream_instr[%0d]: got %h want %h", i, bus.o_instr, 16'h0100 + 16'(i)); end
    end
  endtask

  task automatic test_stall();
    rst = 1'b0; bus.i_ready = 1'b0; tick();
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (bus.o_rom_addr !== 8'((k < 2) ? k : 2)) begin failures++; $display("FAIL stall_addr[%0d]: got %h want %h", k, bus.o_rom_addr, 8'((k < 2) ? k : 2)); end
      checks++; if (bus.o_instr !== 16'h0100) begin failures++; $display("FAIL stall_instr[%0d]: got %h want 0100", k, bus.o_instr); end
    end
    bus.i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.o_instr !== 16'h0100 + 16'(k)) begin failures++; $display("FAIL drain_instr[%0d]: got %h want %h", k, bus.o_instr, 16'h0100 + 16'(k)); end
      checks++; if (bus.o_pc !== 8'(k)) begin failures++; $display("FAIL drain_pc[%0d]: got %h want %h", k, bus.o_pc, 8'(k)); end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] exp_pc;
    bus.i_ready = 1'b1; bus.i_redirect = 1'b1; bus.i_redirect_pc = 8'hFE;
    tick();
    bus.i_redirect = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL wrap_flush_valid: got %b want 0", bus.o_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = 8'hFE + 8'(i);
      checks++; if (bus.o_pc !== exp_pc || bus.o_valid !== 1'b1) begin failures++; $display("FAIL wrap_pc[%0d]: got %h/%b want %h/1", i, bus.o_pc, bus.o_valid, exp_pc); end
    end
  endtask

  task automatic test_halt();
    rom[3] = 16'hE007;
    rst = 1'b0; bus.i_ready = 1'b1; tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.o_pc !== 8'(i)) begin failures++; $display("FAIL halt_pc[%0d]: got %h want %h", i, bus.o_pc, 8'(i)); end
    end
    checks++; if (bus.o_halted !== 1'b1) begin failures++; $display("FAIL halt_flag: got %b want 1", bus.o_halted); end
    checks++; if (bus.o_rom_addr !== 8'h03) begin failures++; $display("FAIL halt_addr: got %h want 03", bus.o_rom_addr); end
    tick(); tick();
    checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL halt_drain_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_rom_addr !== 8'h03) begin failures++; $display("FAIL halt_hold_addr: got %h want 03", bus.o_rom_addr); end
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 8'h10;
    tick();
    bus.i_redirect = 1'b0;
    checks++; if (bus.o_halted !== 1'b0) begin failures++; $display("FAIL halt_release: got %b want 0", bus.o_halted); end
    tick();
    checks++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 8'h10) begin failures++; $display("FAIL halt_redirect_pc: got %b/%h want 1/10", bus.o_valid, bus.o_pc); end
    rom[3] = 16'h0103;
  endtask

  task automatic test_redirect_full();
    rst = 1'b0; bus.i_ready = 1'b0; tick();
    rst = 1'b1; tick(); tick();
    checks++; if (bus.o_rom_addr !== 8'h02) begin failures++; $display("FAIL full_addr: got %h want 02", bus.o_rom_addr); end
    bus.i_redirect = 1'b1; bus.i_ready = 1'b1; bus.i_redirect_pc = 8'h40;
    tick();
    bus.i_redirect = 1'b0;
    checks++; if (bus.o_valid !== 1'b0 || bus.o_rom_addr !== 8'h40) begin failures++; $display("FAIL full_redirect: got %b/%h want 0/40", bus.o_valid, bus.o_rom_addr); end
    tick();
    checks++; if (bus.o_pc !== 8'h40 || bus.o_instr !== 16'h0140) begin failures++; $display("FAIL full_redirect_head: got %h/%h want 40/0140", bus.o_pc, bus.o_instr); end
  endtask

  task automatic test_reset_override();
    bus.i_ready = 1'b0; tick(); tick();
    checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL override_pre_valid: got %b want 1", bus.o_valid); end
    rst = 1'b0; bus.i_redirect = 1'b1; bus.i_redirect_pc = 8'h77;
    tick();
    rst = 1'b1; bus.i_redirect = 1'b0;
    checks++; if (bus.o_valid !== 1'b0 || bus.o_rom_addr !== 8'h00 || bus.o_halted !== 1'b0) begin
      failures++; $display("FAIL override_reset: got valid=%b addr=%h halted=%b want 0/00/0", bus.o_valid, bus.o_rom_addr, bus.o_halted);
    end
  endtask

  task automatic test_random();
    logic [IW-1:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 19) == 0) w = w | 16'hE007;
      rom[i] = w;
    end
    for (int c = 0; c < 800; c++) begin
      rst              = ($urandom_range(0, 99) != 0);
      bus.i_redirect   = ($urandom_range(0, 15) == 0);
      bus.i_redirect_pc = 8'($urandom);
      bus.i_ready      = ($urandom_range(0, 3) != 0);
      tick();
      checks++; if (bus.o_valid !== (mq_pc.size() != 0)) begin failures++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, bus.o_valid, mq_pc.size() != 0); end
      checks++; if (bus.o_rom_addr !== mpc) begin failures++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, bus.o_rom_addr, mpc); end
      checks++; if (bus.o_halted !== mhalt) begin failures++; $display("FAIL rnd_halted[%0d]: got %b want %b", c, bus.o_halted, mhalt); end
      if (mq_pc.size() != 0) begin
        checks++; if (bus.o_pc !== mq_pc[0]) begin failures++; $display("FAIL rnd_pc[%0d]: got %h want %h", c, bus.o_pc, mq_pc[0]); end
        checks++; if (bus.o_instr !== mq_in[0]) begin failures++; $display("FAIL rnd_instr[%0d]: got %h want %h", c, bus.o_instr, mq_in[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_wrap();
    test_halt();
    test_redirect_full();
    test_reset_override();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
